midi_parameter_bank: RTL and testbench

Multi-channel successor to the single-bank MIDI parameter controller. It consumes decoded MIDI messages from the MIDI decoder and keeps NUM_PARAMS synth parameters (modulation, unison, ADSR, volume, ...) per MIDI channel for NUM_CHANNELS channels. Each parameter has a runtime-remappable CC number, programmed through a "MIDI learn" state machine with timeout. It sits between the MIDI decoder and the voice/envelope engines.

---
 rtl/midi_parameter_bank.sv | 159 +++++++++++++++
 tb/tb_midi_parameter_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_parameter_bank.sv
// Per-channel MIDI CC parameter bank with a runtime-remappable CC map and a MIDI-learn FSM.
// Define PARAM_14BIT_EN for 14-bit values (CC n / n+32 MSB/LSB pairing).
module midi_parameter_bank #(
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter int unsigned NUM_PARAMS    = 8,
  parameter logic [6:0]  CC_BASE       = 7'd20,
  parameter logic [6:0]  DEFAULT_VALUE = 7'd64,
  parameter int unsigned LEARN_TIMEOUT = 50_000_000,
  localparam int unsigned SW = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1,
`ifdef PARAM_14BIT_EN
  localparam int unsigned PW = 14
`else
  localparam int unsigned PW = 7
`endif
) (
  input  logic                                 clock_50_000_000,
  input  logic                                 reset_l,
  input  logic                                 message_ready,
  input  logic [3:0]                           msg_status,
  input  logic [3:0]                           msg_channel,
  input  logic [6:0]                           msg_data1,
  input  logic [6:0]                           msg_data2,
  input  logic                                 learn_start,
  input  logic [SW-1:0]                        learn_slot,
  output logic                                 learn_busy,
  output logic                                 learn_done,
  output logic                                 learn_timeout,
  output logic [NUM_CHANNELS*NUM_PARAMS*PW-1:0] parameters,
  output logic [NUM_CHANNELS*NUM_PARAMS-1:0]    parameter_changes
);

  localparam int unsigned NV    = NUM_CHANNELS * NUM_PARAMS;
  localparam int unsigned TW    = (LEARN_TIMEOUT > 2) ? $clog2(LEARN_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(LEARN_TIMEOUT - 1);
  localparam logic [6:0] CC_CTRL_RESET = 7'd121;
  localparam logic [6:0] CC_MODE_FIRST = 7'd120;
`ifdef PARAM_14BIT_EN
  localparam logic [PW-1:0] DEF_PW = {DEFAULT_VALUE, 7'd0};
`else
  localparam logic [PW-1:0] DEF_PW = DEFAULT_VALUE;
`endif

  typedef enum logic [0:0] {ST_IDLE, ST_ARMED} state_e;

  state_e                     state_q, state_d;
  logic [SW-1:0]              slot_q, slot_d;
  logic [TW-1:0]              cnt_q, cnt_d;
  logic [NUM_PARAMS-1:0][6:0] map_q, map_d;
  logic [NV*PW-1:0]           val_q, val_d;
  logic [NV-1:0]              chg_q, chg_d;
  logic                       done_q, done_d;
  logic                       tout_q, tout_d;

  logic accept, mode_msg, learn_ok, start_ok;

  always_comb begin
    accept   = message_ready && (msg_status == 4'hB) && (32'(msg_channel) < NUM_CHANNELS);
    mode_msg = (msg_data1 >= CC_MODE_FIRST);
`ifdef PARAM_14BIT_EN
    learn_ok = accept && (msg_data1 < 7'd32);
`else
    learn_ok = accept && !mode_msg;
`endif
    start_ok = learn_start && (32'(learn_slot) < NUM_PARAMS);
  end

  // Learn FSM plus value/strobe update; writes use the post-learn map so a binding message lands at once.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    map_d   = map_q;
    val_d   = val_q;
    chg_d   = '0;
    done_d  = 1'b0;
    tout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_ARMED;
          slot_d  = learn_slot;
          cnt_d   = '0;
        end
      end
      ST_ARMED: begin
        if (start_ok) begin
          slot_d = learn_slot;
          cnt_d  = '0;
        end else if (learn_ok) begin
          map_d[slot_q] = msg_data1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end else if (cnt_q == TLAST) begin
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (accept && (msg_channel == 4'(c))) begin
        for (int k = 0; k < NUM_PARAMS; k++) begin
          if (msg_data1 == CC_CTRL_RESET) begin
            val_d[(c*NUM_PARAMS+k)*PW +: PW] = DEF_PW;
            chg_d[c*NUM_PARAMS+k]            = 1'b1;
          end else if (!mode_msg) begin
            if (map_d[k] == msg_data1) begin
`ifdef PARAM_14BIT_EN
              val_d[(c*NUM_PARAMS+k)*PW +: PW] = {msg_data2, 7'd0};
`else
              val_d[(c*NUM_PARAMS+k)*PW +: PW] = msg_data2;
`endif
              chg_d[c*NUM_PARAMS+k] = 1'b1;
            end
`ifdef PARAM_14BIT_EN
            else if ((map_d[k] < 7'd32) && ((map_d[k] + 7'd32) == msg_data1)) begin
              val_d[(c*NUM_PARAMS+k)*PW +: 7] = msg_data2;
              chg_d[c*NUM_PARAMS+k]           = 1'b1;
            end
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      chg_q   <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      for (int i = 0; i < NV; i++) val_q[i*PW +: PW] <= DEF_PW;
      for (int k = 0; k < NUM_PARAMS; k++) map_q[k] <= 7'(CC_BASE + 7'(k));
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
      val_q   <= val_d;
      chg_q   <= chg_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign learn_busy        = (state_q == ST_ARMED);
  assign learn_done        = done_q;
  assign learn_timeout     = tout_q;
  assign parameters        = val_q;
  assign parameter_changes = chg_q;

endmodule

// File: tb/tb_midi_parameter_bank.sv
// Directed bench for midi_parameter_bank: CC vector table plus learn / timeout / controller-reset sequences.
module tb_midi_parameter_bank;

`ifdef PARAM_14BIT_EN
  localparam int unsigned PW = 14;
  localparam logic [6:0] LCC = 7'd30;
`else
  localparam int unsigned PW = 7;
  localparam logic [6:0] LCC = 7'd74;
`endif
  localparam int unsigned NCH = 4;
  localparam int unsigned NP  = 8;

  logic clk = 1'b0;
  logic reset_l;
  logic message_ready;
  logic [3:0] msg_status, msg_channel;
  logic [6:0] msg_data1, msg_data2;
  logic learn_start;
  logic [2:0] learn_slot;
  logic learn_busy, learn_done, learn_timeout;
  logic [NCH*NP*PW-1:0] parameters;
  logic [NCH*NP-1:0]    parameter_changes;

  always #10 clk = ~clk;

  midi_parameter_bank #(.LEARN_TIMEOUT(100)) dut (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .message_ready    (message_ready),
    .msg_status       (msg_status),
    .msg_channel      (msg_channel),
    .msg_data1        (msg_data1),
    .msg_data2        (msg_data2),
    .learn_start      (learn_start),
    .learn_slot       (learn_slot),
    .learn_busy       (learn_busy),
    .learn_done       (learn_done),
    .learn_timeout    (learn_timeout),
    .parameters       (parameters),
    .parameter_changes(parameter_changes)
  );

  typedef struct {
    logic [3:0] st;
    logic [3:0] ch;
    logic [6:0] cc;
    logic [6:0] val;
    int         cch;
    int         cslot;
    logic [6:0] exp;
    logic [31:0] chg;
  } vec_t;

  vec_t vecs[8];
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [NCH*NP*PW-1:0] exp_full;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_full(input string name, input logic [NCH*NP*PW-1:0] exp);
    total_cnt++;
    if (parameters === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, parameters, exp);
  endtask

  function automatic logic [PW-1:0] ev(input logic [6:0] v);
`ifdef PARAM_14BIT_EN
    return {v, 7'd0};
`else
    return v;
`endif
  endfunction

  function automatic logic [PW-1:0] sv(input int ch, input int s);
    return parameters[(ch*NP+s)*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cc(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] cc,
                         input logic [6:0] v);
    @(negedge clk);
    msg_status = st; msg_channel = ch; msg_data1 = cc; msg_data2 = v; message_ready = 1'b1;
    @(posedge clk); #1;
    message_ready = 1'b0;
  endtask

  task automatic arm(input logic [2:0] s);
    @(negedge clk);
    learn_start = 1'b1; learn_slot = s;
    @(posedge clk); #1;
    learn_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cycles;
    bit seen;
    vecs[0] = '{4'hB, 4'd0, 7'd20,  7'd10,  0, 0, 7'd10,  32'h0000_0001};
    vecs[1] = '{4'hB, 4'd2, 7'd27,  7'd100, 2, 7, 7'd100, 32'h0080_0000};
    vecs[2] = '{4'hB, 4'd9, 7'd27,  7'd5,   2, 7, 7'd100, 32'h0000_0000};
    vecs[3] = '{4'hB, 4'd3, 7'd20,  7'd127, 3, 0, 7'd127, 32'h0100_0000};
    vecs[4] = '{4'hB, 4'd0, 7'd120, 7'd1,   0, 0, 7'd10,  32'h0000_0000};
    vecs[5] = '{4'h9, 4'd0, 7'd21,  7'd1,   0, 1, 7'd64,  32'h0000_0000};
    vecs[6] = '{4'hB, 4'd1, 7'd22,  7'd0,   1, 2, 7'd0,   32'h0000_0400};
    vecs[7] = '{4'hB, 4'd0, 7'd127, 7'd0,   0, 0, 7'd10,  32'h0000_0000};

    reset_l = 1'b0; message_ready = 1'b0; msg_status = '0; msg_channel = '0;
    msg_data1 = '0; msg_data2 = '0; learn_start = 1'b0; learn_slot = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NCH*NP; i++) exp_full[i*PW +: PW] = ev(7'd64);
    chk_full("reset_params", exp_full);
    chk("reset_chg", 64'(parameter_changes), 64'd0);
    chk("reset_flags", {61'd0, learn_busy, learn_done, learn_timeout}, 64'd0);
    @(negedge clk);
    reset_l = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_cc(vecs[i].st, vecs[i].ch, vecs[i].cc, vecs[i].val);
      chk($sformatf("vec%0d_val", i), 64'(sv(vecs[i].cch, vecs[i].cslot)), 64'(ev(vecs[i].exp)));
      chk($sformatf("vec%0d_chg", i), 64'(parameter_changes), 64'(vecs[i].chg));
      tick();
      chk($sformatf("vec%0d_chg_clr", i), 64'(parameter_changes), 64'd0);
    end
    exp_full[(0*NP+0)*PW +: PW] = ev(7'd10);
    exp_full[(2*NP+7)*PW +: PW] = ev(7'd100);
    exp_full[(3*NP+0)*PW +: PW] = ev(7'd127);
    exp_full[(1*NP+2)*PW +: PW] = ev(7'd0);
    chk_full("table_full", exp_full);

    // learn slot 3 from channel 1, then the new binding applies on every channel
    arm(3'd3);
    chk("learnA_busy", 64'(learn_busy), 64'd1);
    send_cc(4'hB, 4'd1, LCC, 7'd30);
    chk("learnA_done", 64'(learn_done), 64'd1);
    chk("learnA_busy_low", 64'(learn_busy), 64'd0);
    chk("learnA_val", 64'(sv(1, 3)), 64'(ev(7'd30)));
    chk("learnA_chg", 64'(parameter_changes), 64'h800);
    tick();
    chk("learnA_done_clr", 64'(learn_done), 64'd0);
    send_cc(4'hB, 4'd0, LCC, 7'd9);
    chk("learnA_new_map_val", 64'(sv(0, 3)), 64'(ev(7'd9)));
    chk("learnA_new_map_chg", 64'(parameter_changes), 64'h8);
    send_cc(4'hB, 4'd0, 7'd23, 7'd50);
    chk("learnA_old_cc_chg", 64'(parameter_changes), 64'd0);
    chk("learnA_old_cc_val", 64'(sv(0, 3)), 64'(ev(7'd9)));

    // timeout with a controller reset arriving while armed
    arm(3'd5);
    cycles = 0;
    send_cc(4'hB, 4'd3, 7'd121, 7'd0);
    cycles = 1;
    chk("tout_busy_after_121", 64'(learn_busy), 64'd1);
    chk("tout_121_chg", 64'(parameter_changes), 64'hFF00_0000);
    chk("tout_121_val", 64'(sv(3, 0)), 64'(ev(7'd64)));
    seen = 1'b0;
    while (!seen && cycles < 200) begin
      tick();
      cycles++;
      if (learn_timeout) seen = 1'b1;
    end
    chk("tout_cycle", 64'(cycles), 64'd100);
    chk("tout_busy_low", 64'(learn_busy), 64'd0);
    tick();
    chk("tout_pulse_clr", 64'(learn_timeout), 64'd0);
    send_cc(4'hB, 4'd0, 7'd25, 7'd77);
    chk("tout_map_kept_val", 64'(sv(0, 5)), 64'(ev(7'd77)));
    chk("tout_map_kept_chg", 64'(parameter_changes), 64'h20);

    // controller reset on channel 0
    send_cc(4'hB, 4'd0, 7'd21, 7'd5);
    chk("cr_pre_val", 64'(sv(0, 1)), 64'(ev(7'd5)));
    send_cc(4'hB, 4'd0, 7'd121, 7'd0);
    chk("cr_chg", 64'(parameter_changes), 64'hFF);
    chk("cr_s1", 64'(sv(0, 1)), 64'(ev(7'd64)));
    chk("cr_s5", 64'(sv(0, 5)), 64'(ev(7'd64)));
    chk("cr_ch1_s3", 64'(sv(1, 3)), 64'(ev(7'd30)));
    chk("cr_ch1_s2", 64'(sv(1, 2)), 64'(ev(7'd0)));
    tick();
    chk("cr_chg_clr", 64'(parameter_changes), 64'd0);

    // learn_start coincident with a CC in IDLE: old map used, FSM arms
    @(negedge clk);
    learn_start = 1'b1; learn_slot = 3'd6;
    msg_status = 4'hB; msg_channel = 4'd0; msg_data1 = 7'd26; msg_data2 = 7'd11;
    message_ready = 1'b1;
    @(posedge clk); #1;
    learn_start = 1'b0; message_ready = 1'b0;
    chk("coin_val", 64'(sv(0, 6)), 64'(ev(7'd11)));
    chk("coin_chg", 64'(parameter_changes), 64'h40);
    chk("coin_busy", 64'(learn_busy), 64'd1);
    send_cc(4'hB, 4'd0, 7'd15, 7'd12);
    chk("coin_done", 64'(learn_done), 64'd1);
    chk("coin_bind_val", 64'(sv(0, 6)), 64'(ev(7'd12)));
    send_cc(4'hB, 4'd0, 7'd26, 7'd1);
    chk("coin_old_cc_chg", 64'(parameter_changes), 64'd0);

`ifdef PARAM_14BIT_EN
    send_cc(4'hB, 4'd0, 7'd21, 7'd3);
    chk("p14_msb", 64'(sv(0, 1)), 64'h180);
    send_cc(4'hB, 4'd0, 7'd53, 7'd127);
    chk("p14_lsb", 64'(sv(0, 1)), 64'h1FF);
    chk("p14_lsb_chg", 64'(parameter_changes), 64'h2);
    send_cc(4'hB, 4'd0, 7'd21, 7'd4);
    chk("p14_msb_clears_lsb", 64'(sv(0, 1)), 64'h200);
`else
    send_cc(4'hB, 4'd0, 7'd53, 7'd127);
    chk("p7_cc53_chg", 64'(parameter_changes), 64'd0);
    chk("p7_cc53_val", 64'(sv(0, 1)), 64'(ev(7'd64)));
`endif

    // reset while armed restores the default map
    arm(3'd2);
    chk("rstA_busy", 64'(learn_busy), 64'd1);
    @(negedge clk);
    reset_l = 1'b0;
    #1;
    chk("rstA_busy_low", 64'(learn_busy), 64'd0);
    chk("rstA_val", 64'(sv(0, 3)), 64'(ev(7'd64)));
    @(negedge clk);
    reset_l = 1'b1;
    send_cc(4'hB, 4'd0, 7'd23, 7'd8);
    chk("rstA_map_val", 64'(sv(0, 3)), 64'(ev(7'd8)));
    chk("rstA_map_chg", 64'(parameter_changes), 64'h8);
    send_cc(4'hB, 4'd1, LCC, 7'd1);
    chk("rstA_learned_gone", 64'(parameter_changes), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
